// File: rtl/palette_pkg.sv
// Shared types and constants for the palette RAM family.
package palette_pkg;

  localparam int unsigned DATA_W_DEFAULT = 16;
  localparam int unsigned DEPTH_DEFAULT  = 256;

  typedef enum logic [0:0] {FILL_IDLE, FILL_RUN} fill_state_t;

  function automatic int unsigned ADDR_W(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/palette_ram_mp_if.sv
// CPU, fill-control and video signals of palette_ram_mp, bundled for the top-level port.
interface palette_ram_mp_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256
);
  import palette_pkg::*;

  localparam int unsigned AW = ADDR_W(DEPTH);

  logic                  wr_en_i;
  logic [DATA_W/8-1:0]   ben_i;
  logic [AW-1:0]         wr_addr_i;
  logic [DATA_W-1:0]     wr_data_i;
  logic                  wr_ack_o;
  logic                  fill_start_i;
  logic                  fill_busy_o;
  logic                  vid_rd_en_i;
  logic [AW-1:0]         vid_rd_addr_i;
  logic [DATA_W-1:0]     vid_rd_data_o;
  logic                  vid_rd_valid_o;
  logic                  cpu_rd_en_i;
  logic [DATA_W-1:0]     cpu_rd_data_o;

  modport master (
    output wr_en_i, ben_i, wr_addr_i, wr_data_i, fill_start_i, vid_rd_en_i, vid_rd_addr_i,
           cpu_rd_en_i,
    input  wr_ack_o, fill_busy_o, vid_rd_data_o, vid_rd_valid_o, cpu_rd_data_o
  );

  modport slave (
    input  wr_en_i, ben_i, wr_addr_i, wr_data_i, fill_start_i, vid_rd_en_i, vid_rd_addr_i,
           cpu_rd_en_i,
    output wr_ack_o, fill_busy_o, vid_rd_data_o, vid_rd_valid_o, cpu_rd_data_o
  );

endinterface

// File: rtl/palette_ram_mp_core.sv
// Byte-enabled dual-port RAM: port A read/write, port B read-only, both read-first.
module palette_ram_mp_core
  import palette_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      a_re_i,
  input  logic [DATA_W/8-1:0]       a_we_i,
  input  logic [ADDR_W(DEPTH)-1:0]  a_addr_i,
  input  logic [DATA_W-1:0]         a_wdata_i,
  output logic [DATA_W-1:0]         a_rdata_o,
  input  logic                      b_en_i,
  input  logic [ADDR_W(DEPTH)-1:0]  b_addr_i,
  output logic [DATA_W-1:0]         b_rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int n = 0; n < DATA_W / 8; n++) begin
      if (a_we_i[n]) mem[a_addr_i][8*n +: 8] <= a_wdata_i[8*n +: 8];
    end
  end

  // Only the output registers are reset; the array itself is not.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_rdata_o <= '0;
      b_rdata_o <= '0;
    end else begin
      if (a_re_i) a_rdata_o <= mem[a_addr_i];
      if (b_en_i) b_rdata_o <= mem[b_addr_i];
    end
  end

endmodule

// File: rtl/palette_ram_mp.sv
// Palette RAM with CPU write port, pipelined video lookup and hardware fill engine.
// Optional CPU readback is enabled by defining PALETTE_RAM_MP_READBACK_EN.
module palette_ram_mp
  import palette_pkg::*;
#(
  parameter int unsigned       DATA_W        = DATA_W_DEFAULT,
  parameter int unsigned       DEPTH         = DEPTH_DEFAULT,
  parameter int unsigned       RD_LATENCY    = 1,
  parameter int unsigned       FILL_ON_RESET = 1,
  parameter logic [DATA_W-1:0] FILL_VALUE    = '0
) (
  input logic             clk_i,
  input logic             rst_i,
  palette_ram_mp_if.slave bus
);

  localparam int unsigned AW = ADDR_W(DEPTH);
  localparam int unsigned NB = DATA_W / 8;

  fill_state_t       state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              pend_q;
  logic              ack_q;
  logic              vld1_q;
  logic              cpu_go, fill_we, cpu_rd_req;
  logic [NB-1:0]     a_we;
  logic [DATA_W-1:0] a_rdata, b_rdata;

`ifdef PALETTE_RAM_MP_READBACK_EN
  assign cpu_rd_req        = bus.cpu_rd_en_i;
  assign bus.cpu_rd_data_o = a_rdata;
`else
  logic              unused_cpu_rd_en;
  logic [DATA_W-1:0] unused_a_rdata;
  assign unused_cpu_rd_en  = bus.cpu_rd_en_i;
  assign unused_a_rdata    = a_rdata;
  assign cpu_rd_req        = 1'b0;
  assign bus.cpu_rd_data_o = '0;
`endif

  // pend_q carries the auto-fill request across reset release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL_IDLE;
      cnt_q   <= '0;
      pend_q  <= (FILL_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FILL_IDLE: begin
        if (bus.fill_start_i || pend_q) begin
          state_d = FILL_RUN;
          cnt_d   = '0;
        end
      end
      FILL_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) state_d = FILL_IDLE;
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  // A fill start in the same cycle as a CPU request wins; the CPU request waits.
  always_comb begin
    fill_we = 1'b0;
    cpu_go  = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        FILL_IDLE: cpu_go  = !(bus.fill_start_i || pend_q) && (bus.wr_en_i || cpu_rd_req);
        FILL_RUN:  fill_we = 1'b1;
        default:   ;
      endcase
    end
  end

  assign a_we = fill_we ? '1 : ((cpu_go && bus.wr_en_i) ? bus.ben_i : '0);

  palette_ram_mp_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .a_re_i    (cpu_go && cpu_rd_req),
    .a_we_i    (a_we),
    .a_addr_i  (fill_we ? cnt_q : bus.wr_addr_i),
    .a_wdata_i (fill_we ? FILL_VALUE : bus.wr_data_i),
    .a_rdata_o (a_rdata),
    .b_en_i    (bus.vid_rd_en_i),
    .b_addr_i  (bus.vid_rd_addr_i),
    .b_rdata_o (b_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q  <= 1'b0;
      vld1_q <= 1'b0;
    end else begin
      ack_q  <= cpu_go;
      vld1_q <= bus.vid_rd_en_i;
    end
  end

  assign bus.wr_ack_o    = ack_q;
  assign bus.fill_busy_o = (state_q == FILL_RUN);

  if (RD_LATENCY == 2) begin : g_lat2
    logic              vld2_q;
    logic [DATA_W-1:0] data2_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld2_q  <= 1'b0;
        data2_q <= '0;
      end else begin
        vld2_q <= vld1_q;
        if (vld1_q) data2_q <= b_rdata;
      end
    end
    assign bus.vid_rd_valid_o = vld2_q;
    assign bus.vid_rd_data_o  = data2_q;
  end else begin : g_lat1
    assign bus.vid_rd_valid_o = vld1_q;
    assign bus.vid_rd_data_o  = b_rdata;
  end

endmodule

// File: tb/tb_palette_ram_mp.sv
// Bench for palette_ram_mp: dut 0 (latency 1, auto-fill 0x0000), dut 1 (latency 2, manual fill 0xF00D).
module tb_palette_ram_mp;

  logic clk = 1'b0;
  logic r1, r2;
  always #5 clk = ~clk;

  palette_ram_mp_if #(.DATA_W(16), .DEPTH(256)) b1 ();
  palette_ram_mp_if #(.DATA_W(16), .DEPTH(256)) b2 ();

  palette_ram_mp #(
    .DATA_W(16), .DEPTH(256), .RD_LATENCY(1), .FILL_ON_RESET(1), .FILL_VALUE(16'h0000)
  ) dut0 (.clk_i(clk), .rst_i(r1), .bus(b1));

  palette_ram_mp #(
    .DATA_W(16), .DEPTH(256), .RD_LATENCY(2), .FILL_ON_RESET(0), .FILL_VALUE(16'hF00D)
  ) dut1 (.clk_i(clk), .rst_i(r2), .bus(b2));

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_mem   [2][256];
  bit          m_known [2][256];
  bit          m_init [2], m_busy [2], m_pend [2];
  int          m_cnt [2];
  bit          e_ack [2], e_vld [2], e_vd_known [2];
  logic [15:0] e_vd [2], e_rd [2];
  // Lookup results scheduled by the edge number at which they must appear.
  bit          s_v [2][4];
  bit          s_k [2][4];
  logic [15:0] s_d [2][4];
  int          edge_no = 0;

  task automatic step(input int k, input bit rst, input bit we, input logic [1:0] ben,
                      input logic [7:0] a, input logic [15:0] wd, input bit fs,
                      input bit ve, input logic [7:0] va, input bit cre_in);
    logic [15:0] old_a, old_v;
    bit          ka, kv, cre;
    int          lat, slot, s;
    lat  = (k == 0) ? 1 : 2;
    slot = edge_no % 4;
`ifdef PALETTE_RAM_MP_READBACK_EN
    cre = cre_in;
`else
    cre = 1'b0 & cre_in;
`endif
    old_a = m_mem[k][a];
    ka    = m_known[k][a];
    old_v = m_mem[k][va];
    kv    = m_known[k][va];
    e_ack[k] = 1'b0;
    if (rst) begin
      m_init[k] = 1'b1;
      m_busy[k] = 1'b0;
      m_pend[k] = (k == 0);
      for (int i = 0; i < 4; i++) s_v[k][i] = 1'b0;
      e_vld[k] = 1'b0; e_vd[k] = 16'h0; e_vd_known[k] = 1'b1; e_rd[k] = 16'h0;
      return;
    end
    if (ve) begin
      s = (edge_no + lat - 1) % 4;
      s_v[k][s] = 1'b1; s_d[k][s] = old_v; s_k[k][s] = kv;
    end
    e_vld[k] = s_v[k][slot];
    if (s_v[k][slot]) begin
      e_vd[k] = s_d[k][slot]; e_vd_known[k] = s_k[k][slot]; s_v[k][slot] = 1'b0;
    end
    if (m_busy[k]) begin
      m_mem[k][m_cnt[k]]   = (k == 0) ? 16'h0000 : 16'hF00D;
      m_known[k][m_cnt[k]] = 1'b1;
      if (m_cnt[k] == 255) m_busy[k] = 1'b0;
      m_cnt[k]++;
    end else if (fs || m_pend[k]) begin
      m_busy[k] = 1'b1; m_cnt[k] = 0; m_pend[k] = 1'b0;
    end else if (we || cre) begin
      e_ack[k] = 1'b1;
      if (cre) e_rd[k] = ka ? old_a : 16'hxxxx;
      if (we) begin
        for (int n = 0; n < 2; n++)
          if (ben[n]) m_mem[k][a][8*n +: 8] = wd[8*n +: 8];
        if (ben == 2'b11) m_known[k][a] = 1'b1;
      end
    end
  endtask

  always @(posedge clk) begin
    step(0, r1, b1.wr_en_i, b1.ben_i, b1.wr_addr_i, b1.wr_data_i, b1.fill_start_i,
         b1.vid_rd_en_i, b1.vid_rd_addr_i, b1.cpu_rd_en_i);
    step(1, r2, b2.wr_en_i, b2.ben_i, b2.wr_addr_i, b2.wr_data_i, b2.fill_start_i,
         b2.vid_rd_en_i, b2.vid_rd_addr_i, b2.cpu_rd_en_i);
    edge_no++;
  end

  task automatic cmp_dut(input int k, input logic busy, input logic ack, input logic vld,
                         input logic [15:0] vd, input logic [15:0] rd);
    chk($sformatf("m%0d_busy", k), busy, m_busy[k]);
    chk($sformatf("m%0d_ack", k), ack, e_ack[k]);
    chk($sformatf("m%0d_vld", k), vld, e_vld[k]);
    if (e_vd_known[k]) chk($sformatf("m%0d_vdata", k), vd, e_vd[k]);
    if (!$isunknown(e_rd[k])) chk($sformatf("m%0d_rdata", k), rd, e_rd[k]);
  endtask

  always @(negedge clk) begin
    if (m_init[0]) cmp_dut(0, b1.fill_busy_o, b1.wr_ack_o, b1.vid_rd_valid_o,
                           b1.vid_rd_data_o, b1.cpu_rd_data_o);
    if (m_init[1]) cmp_dut(1, b2.fill_busy_o, b2.wr_ack_o, b2.vid_rd_valid_o,
                           b2.vid_rd_data_o, b2.cpu_rd_data_o);
  end

  // ---------------- directed stimulus ----------------
  task automatic wr(input int k, input logic [7:0] a, input logic [15:0] d,
                    input logic [1:0] be, input string nm);
    if (k == 0) begin
      b1.wr_en_i = 1; b1.wr_addr_i = a; b1.wr_data_i = d; b1.ben_i = be;
    end else begin
      b2.wr_en_i = 1; b2.wr_addr_i = a; b2.wr_data_i = d; b2.ben_i = be;
    end
    @(negedge clk);
    chk(nm, (k == 0) ? b1.wr_ack_o : b2.wr_ack_o, 1'b1);
    b1.wr_en_i = 0;
    b2.wr_en_i = 0;
  endtask

  task automatic lookup(input int k, input logic [7:0] a, input logic [15:0] exp,
                        input string nm);
    if (k == 0) begin b1.vid_rd_en_i = 1; b1.vid_rd_addr_i = a; end
    else        begin b2.vid_rd_en_i = 1; b2.vid_rd_addr_i = a; end
    @(negedge clk);
    b1.vid_rd_en_i = 0;
    b2.vid_rd_en_i = 0;
    if (k == 1) @(negedge clk);
    chk({nm, "_vld"}, (k == 0) ? b1.vid_rd_valid_o : b2.vid_rd_valid_o, 1'b1);
    chk(nm, (k == 0) ? b1.vid_rd_data_o : b2.vid_rd_data_o, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    r1 = 1; r2 = 1;
    b1.wr_en_i = 0; b1.ben_i = 0; b1.wr_addr_i = 0; b1.wr_data_i = 0; b1.fill_start_i = 0;
    b1.vid_rd_en_i = 0; b1.vid_rd_addr_i = 0; b1.cpu_rd_en_i = 0;
    b2.wr_en_i = 0; b2.ben_i = 0; b2.wr_addr_i = 0; b2.wr_data_i = 0; b2.fill_start_i = 0;
    b2.vid_rd_en_i = 0; b2.vid_rd_addr_i = 0; b2.cpu_rd_en_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", b1.fill_busy_o, 1'b0);
    chk("rst_vdata", b1.vid_rd_data_o, 16'h0000);

    // Auto-fill after reset release lasts exactly DEPTH cycles.
    r1 = 0;
    @(negedge clk);
    n = 0;
    while (b1.fill_busy_o && n < 400) begin n++; @(negedge clk); end
    chk("fill_len", n, 256);
    lookup(0, 8'd0,   16'h0000, "fill_idx0");
    lookup(0, 8'd128, 16'h0000, "fill_idx128");
    lookup(0, 8'd255, 16'h0000, "fill_idx255");

    wr(0, 8'h05, 16'hABCD, 2'b10, "ack_be10");
    lookup(0, 8'h05, 16'hAB00, "be10_data");
    wr(0, 8'h06, 16'h9999, 2'b00, "ack_be00");
    lookup(0, 8'h06, 16'h0000, "be00_data");
`ifdef PALETTE_RAM_MP_READBACK_EN
    b1.cpu_rd_en_i = 1; b1.wr_addr_i = 8'h05;
    @(negedge clk);
    b1.cpu_rd_en_i = 0;
    chk("rb_ack", b1.wr_ack_o, 1'b1);
    chk("rb_data", b1.cpu_rd_data_o, 16'hAB00);
`endif

    // CPU write issued just after a fill start stalls for the whole fill.
    b1.fill_start_i = 1;
    @(negedge clk);
    b1.fill_start_i = 0;
    b1.wr_en_i = 1; b1.wr_addr_i = 8'h03; b1.wr_data_i = 16'h1234; b1.ben_i = 2'b11;
    n = 0;
    @(negedge clk);
    while (!b1.wr_ack_o && n < 400) begin n++; @(negedge clk); end
    b1.wr_en_i = 0;
    chk("stall_cycles", n, 256);
    lookup(0, 8'h03, 16'h1234, "stall_data");
    lookup(0, 8'h05, 16'h0000, "refill_data");

    // Same-cycle write and lookup of one address returns the old word.
    b1.wr_en_i = 1; b1.wr_addr_i = 8'h07; b1.wr_data_i = 16'h5555; b1.ben_i = 2'b11;
    b1.vid_rd_en_i = 1; b1.vid_rd_addr_i = 8'h07;
    @(negedge clk);
    b1.wr_en_i = 0;
    chk("rf_ack", b1.wr_ack_o, 1'b1);
    chk("rf_old", b1.vid_rd_data_o, 16'h0000);
    @(negedge clk);
    b1.vid_rd_en_i = 0;
    chk("rf_new", b1.vid_rd_data_o, 16'h5555);

    // Second instance: latency 2, no auto-fill.
    r2 = 0;
    repeat (2) @(negedge clk);
    chk("nofill_busy", b2.fill_busy_o, 1'b0);
    for (int i = 0; i < 4; i++) wr(1, i[7:0], 16'h1000 + 16'(i), 2'b11, "l2_wr");
    wr(1, 8'd100, 16'hAAAA, 2'b11, "w100");
    wr(1, 8'd101, 16'hBBBB, 2'b11, "w101");
    wr(1, 8'd200, 16'hCCCC, 2'b11, "w200");
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        chk($sformatf("l2_vld_c%0d", i), b2.vid_rd_valid_o, (i >= 2 && i <= 5));
        if (i >= 2 && i <= 5) chk("l2_data", b2.vid_rd_data_o, 16'h1000 + 16'(i - 2));
      end
      b2.vid_rd_en_i = (i < 4);
      b2.vid_rd_addr_i = i[7:0];
      @(negedge clk);
    end

    // Fill aborted by reset in its 100th cycle; a start pulse mid-fill is ignored.
    b2.fill_start_i = 1;
    @(negedge clk);
    b2.fill_start_i = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      b2.fill_start_i = (i == 49);
    end
    r2 = 1;
    @(negedge clk);
    r2 = 0;
    chk("abort_busy", b2.fill_busy_o, 1'b0);
    @(negedge clk);
    chk("abort_norestart", b2.fill_busy_o, 1'b0);
    lookup(1, 8'd0,   16'hF00D, "abort_e0");
    lookup(1, 8'd99,  16'hF00D, "abort_e99");
    lookup(1, 8'd100, 16'hAAAA, "abort_e100");
    lookup(1, 8'd101, 16'hBBBB, "abort_e101");
    lookup(1, 8'd200, 16'hCCCC, "abort_e200");
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
